// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe_if
//  Description : Signal bundle between the ID-stage datapath and the pipelined
//                control unit (ctrl_pipe).
//                master : drives opcode/register fields and the branch compare.
//                slave  : the control unit; drives hazard, decode and
//                         per-stage control outputs.
//                Optional macro CTRL_JAL_EN adds wb_link_o.
//  Revision    : 1.0  initial release
// ============================================================================
interface ctrl_pipe_if #(
    parameter int OP_W  = 6,
    parameter int REG_W = 5,
    parameter int CNT_W = 8
);
    // ID-stage inputs to the control unit
    logic [OP_W-1:0]  op_i;
    logic [REG_W-1:0] rs_i;
    logic [REG_W-1:0] rt_i;
    logic             branch_taken_i;

    // Hazard / ID-stage decode
    logic             stall_o;
    logic             flush_o;
    logic             jump_o;
    logic             branch_o;

    // Per-stage registered controls
    logic             ex_alusrc_o;
    logic [1:0]       ex_aluop_o;
    logic             ex_regdst_o;
    logic             mem_write_o;
    logic             mem_read_o;
    logic             wb_regwrite_o;
    logic             wb_memtoreg_o;
    logic [CNT_W-1:0] ill_cnt_o;
`ifdef CTRL_JAL_EN
    logic             wb_link_o;
`endif

    modport master (
        output op_i, rs_i, rt_i, branch_taken_i,
        input  stall_o, flush_o, jump_o, branch_o,
               ex_alusrc_o, ex_aluop_o, ex_regdst_o,
               mem_write_o, mem_read_o,
               wb_regwrite_o, wb_memtoreg_o, ill_cnt_o
`ifdef CTRL_JAL_EN
             , wb_link_o
`endif
    );

    modport slave (
        input  op_i, rs_i, rt_i, branch_taken_i,
        output stall_o, flush_o, jump_o, branch_o,
               ex_alusrc_o, ex_aluop_o, ex_regdst_o,
               mem_write_o, mem_read_o,
               wb_regwrite_o, wb_memtoreg_o, ill_cnt_o
`ifdef CTRL_JAL_EN
             , wb_link_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : Pipelined control unit for the 5-stage MIPS core. Decodes the
//                ID opcode, carries EX/MEM/WB control bundles through ID/EX,
//                EX/MEM and MEM/WB registers, detects load-use hazards,
//                raises jump/taken-branch flush and counts illegal opcodes
//                (saturating).
//  Ports       : clk_i  - clock, rising edge
//                rst_i  - asynchronous active-low reset
//                bus    - ctrl_pipe_if.slave (ID fields in, controls out)
//  Options     : CTRL_JAL_EN - decode jal (000011) and add bus.wb_link_o
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipe #(
    parameter int OP_W  = 6,
    parameter int REG_W = 5,
    parameter int CNT_W = 8
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    ctrl_pipe_if.slave  bus
);

    localparam logic [OP_W-1:0]  OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]  OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0]  OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]  OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]  OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]  OP_J     = OP_W'(6'b000010);
`ifdef CTRL_JAL_EN
    localparam logic [OP_W-1:0]  OP_JAL   = OP_W'(6'b000011);
`endif
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // ID-stage decode
    // ------------------------------------------------------------------
    logic       dec_alusrc;
    logic [1:0] dec_aluop;
    logic       dec_regdst;
    logic       dec_memread;
    logic       dec_memwrite;
    logic       dec_regwrite;
    logic       dec_memtoreg;
    logic       dec_jump;
    logic       dec_branch;
    logic       dec_uses_rt;
    logic       dec_illegal;
`ifdef CTRL_JAL_EN
    logic       dec_link;
`endif

    always_comb begin
        dec_alusrc   = 1'b0;
        dec_aluop    = 2'b00;
        dec_regdst   = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_regwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_jump     = 1'b0;
        dec_branch   = 1'b0;
        dec_uses_rt  = 1'b0;
        dec_illegal  = 1'b0;
`ifdef CTRL_JAL_EN
        dec_link     = 1'b0;
`endif
        case (bus.op_i)
            OP_RTYPE: begin
                dec_aluop    = 2'b10;
                dec_regdst   = 1'b1;
                dec_regwrite = 1'b1;
                dec_uses_rt  = 1'b1;
            end
            OP_ADDI: begin
                dec_alusrc   = 1'b1;
                dec_regwrite = 1'b1;
            end
            OP_LW: begin
                dec_alusrc   = 1'b1;
                dec_memread  = 1'b1;
                dec_regwrite = 1'b1;
                dec_memtoreg = 1'b1;
            end
            OP_SW: begin
                dec_alusrc   = 1'b1;
                dec_memwrite = 1'b1;
                dec_uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                dec_aluop    = 2'b01;
                dec_branch   = 1'b1;
                dec_uses_rt  = 1'b1;
            end
            OP_J: begin
                dec_jump     = 1'b1;
            end
`ifdef CTRL_JAL_EN
            OP_JAL: begin
                dec_jump     = 1'b1;
                dec_regwrite = 1'b1;
                dec_link     = 1'b1;
            end
`endif
            default: begin
                dec_illegal  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control registers
    // ------------------------------------------------------------------
    logic             idex_alusrc_q,   idex_alusrc_d;
    logic [1:0]       idex_aluop_q,    idex_aluop_d;
    logic             idex_regdst_q,   idex_regdst_d;
    logic             idex_memread_q,  idex_memread_d;
    logic             idex_memwrite_q, idex_memwrite_d;
    logic             idex_regwrite_q, idex_regwrite_d;
    logic             idex_memtoreg_q, idex_memtoreg_d;
    logic [REG_W-1:0] idex_rt_q,       idex_rt_d;
    logic             exmem_memread_q;
    logic             exmem_memwrite_q;
    logic             exmem_regwrite_q;
    logic             exmem_memtoreg_q;
    logic             memwb_regwrite_q;
    logic             memwb_memtoreg_q;
    logic [CNT_W-1:0] ill_cnt_q,       ill_cnt_d;
`ifdef CTRL_JAL_EN
    logic             idex_link_q, idex_link_d;
    logic             exmem_link_q;
    logic             memwb_link_q;
`endif

    // ------------------------------------------------------------------
    // Hazard detection. A zero rt in ID/EX never stalls because r0 is
    // hard-wired and bubbles carry rt=0.
    // ------------------------------------------------------------------
    logic stall;
    logic flush;

    always_comb begin
        stall = idex_memread_q && (idex_rt_q != '0) &&
                ((idex_rt_q == bus.rs_i) || (dec_uses_rt && (idex_rt_q == bus.rt_i)));
        // A beq waiting on a load resolves only once the stall clears.
        flush = !stall && (dec_jump || (dec_branch && bus.branch_taken_i));
    end

    // ------------------------------------------------------------------
    // ID/EX next state: bubble on stall; illegal count only for opcodes
    // actually accepted, so a held opcode is counted once.
    // ------------------------------------------------------------------
    always_comb begin
        idex_alusrc_d   = 1'b0;
        idex_aluop_d    = 2'b00;
        idex_regdst_d   = 1'b0;
        idex_memread_d  = 1'b0;
        idex_memwrite_d = 1'b0;
        idex_regwrite_d = 1'b0;
        idex_memtoreg_d = 1'b0;
        idex_rt_d       = '0;
`ifdef CTRL_JAL_EN
        idex_link_d     = 1'b0;
`endif
        ill_cnt_d       = ill_cnt_q;
        if (!stall) begin
            idex_alusrc_d   = dec_alusrc;
            idex_aluop_d    = dec_aluop;
            idex_regdst_d   = dec_regdst;
            idex_memread_d  = dec_memread;
            idex_memwrite_d = dec_memwrite;
            idex_regwrite_d = dec_regwrite;
            idex_memtoreg_d = dec_memtoreg;
            idex_rt_d       = bus.rt_i;
`ifdef CTRL_JAL_EN
            idex_link_d     = dec_link;
`endif
            if (dec_illegal && (ill_cnt_q != CNT_MAX)) begin
                ill_cnt_d = ill_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_alusrc_q    <= 1'b0;
            idex_aluop_q     <= 2'b00;
            idex_regdst_q    <= 1'b0;
            idex_memread_q   <= 1'b0;
            idex_memwrite_q  <= 1'b0;
            idex_regwrite_q  <= 1'b0;
            idex_memtoreg_q  <= 1'b0;
            idex_rt_q        <= '0;
            exmem_memread_q  <= 1'b0;
            exmem_memwrite_q <= 1'b0;
            exmem_regwrite_q <= 1'b0;
            exmem_memtoreg_q <= 1'b0;
            memwb_regwrite_q <= 1'b0;
            memwb_memtoreg_q <= 1'b0;
            ill_cnt_q        <= '0;
`ifdef CTRL_JAL_EN
            idex_link_q      <= 1'b0;
            exmem_link_q     <= 1'b0;
            memwb_link_q     <= 1'b0;
`endif
        end else begin
            idex_alusrc_q    <= idex_alusrc_d;
            idex_aluop_q     <= idex_aluop_d;
            idex_regdst_q    <= idex_regdst_d;
            idex_memread_q   <= idex_memread_d;
            idex_memwrite_q  <= idex_memwrite_d;
            idex_regwrite_q  <= idex_regwrite_d;
            idex_memtoreg_q  <= idex_memtoreg_d;
            idex_rt_q        <= idex_rt_d;
            // Later stages never stall or flush.
            exmem_memread_q  <= idex_memread_q;
            exmem_memwrite_q <= idex_memwrite_q;
            exmem_regwrite_q <= idex_regwrite_q;
            exmem_memtoreg_q <= idex_memtoreg_q;
            memwb_regwrite_q <= exmem_regwrite_q;
            memwb_memtoreg_q <= exmem_memtoreg_q;
            ill_cnt_q        <= ill_cnt_d;
`ifdef CTRL_JAL_EN
            idex_link_q      <= idex_link_d;
            exmem_link_q     <= idex_link_q;
            memwb_link_q     <= exmem_link_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.stall_o       = stall;
    assign bus.flush_o       = flush;
    assign bus.jump_o        = dec_jump;
    assign bus.branch_o      = dec_branch;
    assign bus.ex_alusrc_o   = idex_alusrc_q;
    assign bus.ex_aluop_o    = idex_aluop_q;
    assign bus.ex_regdst_o   = idex_regdst_q;
    assign bus.mem_write_o   = exmem_memwrite_q;
    assign bus.mem_read_o    = exmem_memread_q;
    assign bus.wb_regwrite_o = memwb_regwrite_q;
    assign bus.wb_memtoreg_o = memwb_memtoreg_q;
    assign bus.ill_cnt_o     = ill_cnt_q;
`ifdef CTRL_JAL_EN
    assign bus.wb_link_o     = memwb_link_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Self-checking bench for ctrl_pipe. A vector table drives the
//                main decode/hazard sequence; hand-written sequences cover
//                asynchronous reset, jal and counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] JAL = 6'b000011;
    localparam logic [5:0] ILL = 6'b111111;
    localparam int         NV  = 21;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   base;

    ctrl_pipe_if #(.OP_W(6), .REG_W(5), .CNT_W(8)) bus ();

    ctrl_pipe #(.OP_W(6), .REG_W(5), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected: stall/flush/jump/branch combinationally while the vector is
    // applied; ex={alusrc,aluop,regdst}, mem={write,read}, wb={regwrite,
    // memtoreg} and cnt after the following rising edge.
    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       tk;
        logic       stall;
        logic       flush;
        logic       jump;
        logic       branch;
        logic [3:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic tk);
        bus.op_i           = op;
        bus.rs_i           = rs;
        bus.rt_i           = rt;
        bus.branch_taken_i = tk;
    endtask

    function automatic logic [3:0] ex_bits();
        return {bus.ex_alusrc_o, bus.ex_aluop_o, bus.ex_regdst_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //          op   rs     rt     tk    st    fl    jp    br    ex       mem    wb     cnt
        vt[0]  = '{R,   5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b00, 2'b00, 8'd0};
        vt[1]  = '{ADI, 5'd3,  5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b00, 8'd0};
        vt[2]  = '{LW,  5'd1,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b10, 8'd0};
        vt[3]  = '{SW,  5'd6,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b01, 2'b10, 8'd0};
        vt[4]  = '{R,   5'd8,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b10, 2'b11, 8'd0};
        vt[5]  = '{LW,  5'd0,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b00, 8'd0};
        vt[6]  = '{R,   5'd5,  5'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b01, 2'b10, 8'd0};
        vt[7]  = '{R,   5'd5,  5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b00, 2'b11, 8'd0};
        vt[8]  = '{LW,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b00, 8'd0};
        vt[9]  = '{R,   5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b01, 2'b10, 8'd0};
        vt[10] = '{BEQ, 5'd1,  5'd2,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b00, 2'b11, 8'd0};
        vt[11] = '{BEQ, 5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 2'b00, 2'b10, 8'd0};
        vt[12] = '{LW,  5'd0,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b00, 8'd0};
        vt[13] = '{BEQ, 5'd4,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'b01, 2'b00, 8'd0};
        vt[14] = '{BEQ, 5'd4,  5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 2'b00, 2'b11, 8'd0};
        vt[15] = '{J,   5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00, 8'd0};
        vt[16] = '{SW,  5'd2,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b00, 8'd0};
        vt[17] = '{ILL, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b10, 2'b00, 8'd1};
        vt[18] = '{LW,  5'd0,  5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 2'b00, 2'b00, 8'd1};
        vt[19] = '{ILL, 5'd6,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b01, 2'b00, 8'd1};
        vt[20] = '{ILL, 5'd6,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00, 2'b11, 8'd2};

        // ---------------- power-on reset ----------------
        rst = 1'b0;
        drive(R, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset ex",    32'(ex_bits()), 32'h0);
        chk("reset mem",   32'({bus.mem_write_o, bus.mem_read_o}), 32'h0);
        chk("reset wb",    32'({bus.wb_regwrite_o, bus.wb_memtoreg_o}), 32'h0);
        chk("reset cnt",   32'(bus.ill_cnt_o), 32'h0);
        chk("reset stall", 32'(bus.stall_o), 32'h0);
        rst = 1'b1;

        // ---------------- table-driven sequence ----------------
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].op, vt[i].rs, vt[i].rt, vt[i].tk);
            #2;
            chk($sformatf("v%0d stall", i),  32'(bus.stall_o),  32'(vt[i].stall));
            chk($sformatf("v%0d flush", i),  32'(bus.flush_o),  32'(vt[i].flush));
            chk($sformatf("v%0d jump", i),   32'(bus.jump_o),   32'(vt[i].jump));
            chk($sformatf("v%0d branch", i), 32'(bus.branch_o), 32'(vt[i].branch));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex", i),  32'(ex_bits()), 32'(vt[i].ex));
            chk($sformatf("v%0d mem", i), 32'({bus.mem_write_o, bus.mem_read_o}), 32'(vt[i].mem));
            chk($sformatf("v%0d wb", i),  32'({bus.wb_regwrite_o, bus.wb_memtoreg_o}), 32'(vt[i].wb));
            chk($sformatf("v%0d cnt", i), 32'(bus.ill_cnt_o), 32'(vt[i].cnt));
        end

        // ---------------- asynchronous reset with lw in flight ----------------
        drive(LW, 5'd0, 5'd9, 1'b0);
        @(posedge clk);
        #1;
        drive(R, 5'd1, 5'd2, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst ex",    32'(ex_bits()), 32'h0);
        chk("arst mem",   32'({bus.mem_write_o, bus.mem_read_o}), 32'h0);
        chk("arst wb",    32'({bus.wb_regwrite_o, bus.wb_memtoreg_o}), 32'h0);
        chk("arst cnt",   32'(bus.ill_cnt_o), 32'h0);
        chk("arst stall", 32'(bus.stall_o), 32'h0);
        drive(J, 5'd0, 5'd0, 1'b0);
        #1;
        chk("arst jump comb",  32'(bus.jump_o),  32'h1);
        chk("arst flush comb", 32'(bus.flush_o), 32'h1);
        drive(R, 5'd1, 5'd2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release ex", 32'(ex_bits()), 32'h5);

        // ---------------- jal ----------------
        drive(JAL, 5'd0, 5'd0, 1'b0);
        #2;
`ifdef CTRL_JAL_EN
        chk("jal jump",  32'(bus.jump_o),  32'h1);
        chk("jal flush", 32'(bus.flush_o), 32'h1);
        base = 0;
`else
        chk("op3 jump",  32'(bus.jump_o),  32'h0);
        chk("op3 flush", 32'(bus.flush_o), 32'h0);
        base = 1;
`endif
        @(posedge clk);
        #1;
        chk("op3 ex",  32'(ex_bits()), 32'h0);
        chk("op3 cnt", 32'(bus.ill_cnt_o), 32'(base));
        drive(R, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
`ifdef CTRL_JAL_EN
        chk("jal wb regwrite", 32'(bus.wb_regwrite_o), 32'h1);
        chk("jal wb link",     32'(bus.wb_link_o),     32'h1);
`else
        chk("op3 wb regwrite", 32'(bus.wb_regwrite_o), 32'h0);
`endif
        chk("op3 wb memtoreg", 32'(bus.wb_memtoreg_o), 32'h0);

        // ---------------- illegal counter saturation ----------------
        drive(ILL, 5'd0, 5'd0, 1'b0);
        repeat (254 - base) @(posedge clk);
        #1;
        chk("sat cnt 254", 32'(bus.ill_cnt_o), 32'd254);
        @(posedge clk);
        #1;
        chk("sat cnt 255", 32'(bus.ill_cnt_o), 32'd255);
        repeat (45) @(posedge clk);
        #1;
        chk("sat cnt hold", 32'(bus.ill_cnt_o), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
